// File: rtl/time_set_ctrl_pkg.sv
// Shared types and constants for the button-driven time-setting controller.
package time_set_ctrl_pkg;

    localparam int unsigned HRS_W   = 5;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned SEC_W   = 6;
    localparam int unsigned FIELD_W = 2;
    localparam int unsigned TIME_W  = HRS_W + MIN_W + SEC_W;

    localparam logic [HRS_W-1:0] HRS_MAX = HRS_W'(23);
    localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(59);
    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(59);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EDIT_HRS = 3'd1,
        ST_EDIT_MIN = 3'd2,
        ST_EDIT_SEC = 3'd3,
        ST_COMMIT   = 3'd4
    } state_e;

    typedef enum logic [FIELD_W-1:0] {
        FIELD_NONE = 2'd0,
        FIELD_HRS  = 2'd1,
        FIELD_MIN  = 2'd2,
        FIELD_SEC  = 2'd3
    } field_e;

    typedef struct packed {
        logic [HRS_W-1:0] hrs;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } time_t;

    // Hours step with explicit wrap, kept at field width.
    function automatic logic [HRS_W-1:0] step_hrs(input logic [HRS_W-1:0] v, input logic up);
        if (up) return (v >= HRS_MAX) ? '0 : v + HRS_W'(1);
        else    return (v == '0) ? HRS_MAX : v - HRS_W'(1);
    endfunction

    // Minutes/seconds step with explicit wrap.
    function automatic logic [MIN_W-1:0] step_ms(input logic [MIN_W-1:0] v,
                                                 input logic [MIN_W-1:0] max,
                                                 input logic up);
        if (up) return (v >= max) ? '0 : v + MIN_W'(1);
        else    return (v == '0) ? max : v - MIN_W'(1);
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button inputs and committed/edit-status outputs of the time-setting controller.
interface time_set_ctrl_if;
    import time_set_ctrl_pkg::*;

    logic                btn_mode_i;
    logic                btn_up_i;
    logic                btn_down_i;
    logic [HRS_W-1:0]    set_hrs_o;
    logic [MIN_W-1:0]    set_min_o;
    logic [SEC_W-1:0]    set_sec_o;
    logic                load_o;
    logic                editing_o;
    logic [FIELD_W-1:0]  field_o;
    logic [TIME_W-1:0]   shadow_o;

    modport master (
        output btn_mode_i, btn_up_i, btn_down_i,
        input  set_hrs_o, set_min_o, set_sec_o, load_o, editing_o, field_o, shadow_o
    );

    modport slave (
        input  btn_mode_i, btn_up_i, btn_down_i,
        output set_hrs_o, set_min_o, set_sec_o, load_o, editing_o, field_o, shadow_o
    );

endinterface

// File: rtl/time_set_ctrl_btn_repeat.sv
// Rising-edge detect plus hold-to-repeat timing; step_c pulses on press, after the
// initial delay, then once per repeat period until release.
module btn_repeat #(
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    input  logic inhibit_i,
    output logic press_c,
    output logic step_c
);

    localparam int unsigned MAX_CNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    logic             btn_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;

    assign press_c = btn_i & ~btn_q;

    // cnt_q holds cycles since the last step; zero means not counting.
    always_comb begin
        step_c = 1'b0;
        cnt_d  = cnt_q;
        rep_d  = rep_q;
        if (!btn_i || inhibit_i) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (press_c) begin
            step_c = 1'b1;
            cnt_d  = CNT_W'(1);
            rep_d  = 1'b0;
        end else if (cnt_q != '0) begin
            if ((!rep_q && cnt_q == CNT_W'(REPEAT_DELAY)) ||
                ( rep_q && cnt_q == CNT_W'(REPEAT_RATE))) begin
                step_c = 1'b1;
                cnt_d  = CNT_W'(1);
                rep_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            btn_q <= 1'b0;
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            btn_q <= btn_i;
            cnt_q <= cnt_d;
            rep_q <= rep_d;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven hours/minutes/seconds preset editor with commit strobe and edit status.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int unsigned INIT_HRS     = 17,
    parameter int unsigned INIT_MIN     = 35,
    parameter int unsigned INIT_SEC     = 42,
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100,
    parameter int unsigned TIMEOUT      = 10000
) (
    input  logic            clk_i,
    input  logic            reset_i,
    time_set_ctrl_if.slave  bus
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam time_t INIT_TIME = '{hrs: HRS_W'(INIT_HRS), min: MIN_W'(INIT_MIN), sec: SEC_W'(INIT_SEC)};

    state_e              state_q, state_d;
    time_t               shadow_q, shadow_d;
    time_t               set_q, set_d;
    logic                load_q, load_d;
    logic                editing_q, editing_d;
    field_e              field_q, field_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic                mode_q;

    logic mode_press_c, up_press_c, down_press_c, up_step_c, down_step_c;
    logic both_held_c, any_press_c, in_edit_c, timeout_c;

    assign mode_press_c = bus.btn_mode_i & ~mode_q;
    assign both_held_c  = bus.btn_up_i & bus.btn_down_i;
    assign any_press_c  = mode_press_c | up_press_c | down_press_c;
    assign in_edit_c    = (state_q == ST_EDIT_HRS) || (state_q == ST_EDIT_MIN) || (state_q == ST_EDIT_SEC);
    assign timeout_c    = in_edit_c && (idle_cnt_q == IDLE_W'(TIMEOUT - 1));

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .btn_i     (bus.btn_up_i),
        .inhibit_i (both_held_c),
        .press_c   (up_press_c),
        .step_c    (up_step_c)
    );

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_down (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .btn_i     (bus.btn_down_i),
        .inhibit_i (both_held_c),
        .press_c   (down_press_c),
        .step_c    (down_step_c)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // A mode press always takes priority over an expiring idle timer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (mode_press_c) state_d = ST_EDIT_HRS;
            ST_EDIT_HRS: if (mode_press_c) state_d = ST_EDIT_MIN;
                         else if (timeout_c && !any_press_c) state_d = ST_IDLE;
            ST_EDIT_MIN: if (mode_press_c) state_d = ST_EDIT_SEC;
                         else if (timeout_c && !any_press_c) state_d = ST_IDLE;
            ST_EDIT_SEC: if (mode_press_c) state_d = ST_COMMIT;
                         else if (timeout_c && !any_press_c) state_d = ST_IDLE;
            ST_COMMIT:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, shadow and idle counter.
    always_comb begin
        shadow_d   = shadow_q;
        set_d      = set_q;
        load_d     = 1'b0;
        editing_d  = 1'b0;
        field_d    = FIELD_NONE;
        idle_cnt_d = '0;
        case (state_q)
            ST_IDLE: if (mode_press_c) shadow_d = set_q;
            ST_EDIT_HRS: if (!mode_press_c && (up_step_c || down_step_c))
                shadow_d.hrs = step_hrs(shadow_q.hrs, up_step_c);
            ST_EDIT_MIN: if (!mode_press_c && (up_step_c || down_step_c))
                shadow_d.min = step_ms(shadow_q.min, MIN_MAX, up_step_c);
            ST_EDIT_SEC: if (!mode_press_c && (up_step_c || down_step_c))
                shadow_d.sec = step_ms(shadow_q.sec, SEC_MAX, up_step_c);
            default: ;
        endcase
        if (state_d == ST_COMMIT) begin
            set_d  = shadow_q;
            load_d = 1'b1;
        end
        if (in_edit_c && state_d == ST_IDLE) shadow_d = set_q;
        case (state_d)
            ST_EDIT_HRS: begin editing_d = 1'b1; field_d = FIELD_HRS; end
            ST_EDIT_MIN: begin editing_d = 1'b1; field_d = FIELD_MIN; end
            ST_EDIT_SEC: begin editing_d = 1'b1; field_d = FIELD_SEC; end
            default: ;
        endcase
        if (editing_d && !any_press_c) idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shadow_q   <= INIT_TIME;
            set_q      <= INIT_TIME;
            load_q     <= 1'b0;
            editing_q  <= 1'b0;
            field_q    <= FIELD_NONE;
            idle_cnt_q <= '0;
            mode_q     <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            set_q      <= set_d;
            load_q     <= load_d;
            editing_q  <= editing_d;
            field_q    <= field_d;
            idle_cnt_q <= idle_cnt_d;
            mode_q     <= bus.btn_mode_i;
        end
    end

    assign bus.set_hrs_o = set_q.hrs;
    assign bus.set_min_o = set_q.min;
    assign bus.set_sec_o = set_q.sec;
    assign bus.load_o    = load_q;
    assign bus.editing_o = editing_q;
    assign bus.field_o   = field_q;
    assign bus.shadow_o  = shadow_q;

endmodule
